// File: rtl/comp_mon_pkg.sv
// comp_mon_pkg
// Shared types and constants for the comparator decision monitor:
// FSM state encoding, decision class encoding, comparator indices,
// default sizing, and the (p,m) -> class decode.
package comp_mon_pkg;

  localparam int NCOMP_DEF       = 3;
  localparam int CNT_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;

  localparam int IDX_NAND = 0;
  localparam int IDX_AO22 = 1;
  localparam int IDX_MX21 = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_ONE  = 2'd1,
    CLS_ERR  = 2'd2
  } cls_t;

  // Equal outputs on both legs mean the comparator never resolved.
  function automatic cls_t classify(input logic p, input logic m);
    cls_t c;
    case ({p, m})
      2'b10:   c = CLS_ONE;
      2'b01:   c = CLS_ZERO;
      default: c = CLS_ERR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/comp_pair_counter.sv
// comp_pair_counter
// Per-comparator result counters. Classifies one synchronised (p,m) pair
// per enabled edge and accumulates ones and unresolved decisions, each
// saturating at all-ones so a long window never wraps back to a small value.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   p, m         synchronised VoutP / VoutM
//   clear        zero both counters (start of a new window)
//   count_en     take one sample this edge
//   ones, err    saturating ones / unresolved counts
module comp_pair_counter
  import comp_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p,
  input  logic             m,
  input  logic             clear,
  input  logic             count_en,
  output logic [CNT_W-1:0] ones,
  output logic [CNT_W-1:0] err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1);

  cls_t cls;
  assign cls = classify(p, m);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones <= '0;
      err  <= '0;
    end else if (clear) begin
      ones <= '0;
      err  <= '0;
    end else if (count_en) begin
      if (cls == CLS_ONE && ones != CNT_MAX) ones <= ones + CNT_INC;
      if (cls == CLS_ERR && err != CNT_MAX)  err  <= err + CNT_INC;
    end
  end

endmodule

// File: rtl/comp_decision_monitor.sv
// comp_decision_monitor
// Synchronises NCOMP comparator VoutP/VoutM pairs, counts ones and
// unresolved decisions over a programmable window, and exposes the held
// results through a select mux.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; counters hold their reset/cleared value
// ARM   | SYNC_STAGES edges flushing pre-start data from the synchroniser
// RUN   | one sample per edge per comparator until win_len samples taken
// DONE  | results frozen and valid; start re-arms a new window
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   comp_p, comp_m     asynchronous comparator outputs
//   start              level-sampled in IDLE/DONE
//   win_len            window length, 0 means 2^CNT_W
//   sel_comp           result select, out-of-range reads zero
//   busy, done         registered status
//   ones_cnt, err_cnt  selected comparator's counts (live during ARM/RUN)
module comp_decision_monitor
  import comp_mon_pkg::*;
#(
  parameter int NCOMP       = NCOMP_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCOMP-1:0] comp_p,
  input  logic [NCOMP-1:0] comp_m,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  input  logic [1:0]       sel_comp,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int ARM_W = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;
  localparam logic [CNT_W:0] WIN_INC = (CNT_W + 1)'(1);

  logic [NCOMP-1:0] sync_p [SYNC_STAGES];
  logic [NCOMP-1:0] sync_m [SYNC_STAGES];
  logic [NCOMP-1:0] p_s;
  logic [NCOMP-1:0] m_s;

  state_t           state;
  logic [CNT_W:0]   win_cnt;
  logic [CNT_W:0]   win_tgt;
  logic [CNT_W:0]   win_next;
  logic [ARM_W-1:0] arm_cnt;
  logic             clear_cnt;
  logic             count_en;

  logic [CNT_W-1:0] ones_arr [NCOMP];
  logic [CNT_W-1:0] err_arr  [NCOMP];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_p[i] <= '0;
        sync_m[i] <= '0;
      end
    end else begin
      sync_p[0] <= comp_p;
      sync_m[0] <= comp_m;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_p[i] <= sync_p[i-1];
        sync_m[i] <= sync_m[i-1];
      end
    end
  end

  assign p_s = sync_p[SYNC_STAGES-1];
  assign m_s = sync_m[SYNC_STAGES-1];

  // Clearing happens on the same edge that accepts start, so a restart
  // from DONE never shows the old result during ARM.
  assign clear_cnt = start && (state == IDLE || state == DONE);
  assign count_en  = (state == RUN);
  assign win_next  = win_cnt + WIN_INC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      win_cnt <= '0;
      win_tgt <= '0;
      arm_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= ARM;
            busy    <= 1'b1;
            done    <= 1'b0;
            win_cnt <= '0;
            win_tgt <= (win_len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, win_len};
            arm_cnt <= ARM_W'(SYNC_STAGES - 1);
          end
        end
        ARM: begin
          if (arm_cnt == '0) state <= RUN;
          else               arm_cnt <= arm_cnt - ARM_W'(1);
        end
        RUN: begin
          win_cnt <= win_next;
          if (win_next == win_tgt) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NCOMP; c++) begin : g_pair
    comp_pair_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .p        (p_s[c]),
      .m        (m_s[c]),
      .clear    (clear_cnt),
      .count_en (count_en),
      .ones     (ones_arr[c]),
      .err      (err_arr[c])
    );
  end

  always_comb begin
    ones_cnt = '0;
    err_cnt  = '0;
    for (int c = 0; c < NCOMP; c++) begin
      if (int'(sel_comp) == c) begin
        ones_cnt = ones_arr[c];
        err_cnt  = err_arr[c];
      end
    end
  end

endmodule
